// File: rtl/mem_dmem_access.sv
// MEM-stage data-memory access unit: issues one req/ack bus transaction per
// load/store, stalls the pipeline while it is outstanding, and aligns/extends load data.
module mem_dmem_access #(
  parameter int XLEN = 64
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            mem_valid,
  input  logic            mem_is_write_dmem,
  input  logic            mem_is_read_dmem,
  input  logic [7:0]      mem_write_width,
  input  logic            mem_load_unsigned,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_dmem_write_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [7:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            misalign_err,
  output logic            wb_load_valid,
  output logic [XLEN-1:0] wb_load_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [7:0]      dmem_wstrb_q, dmem_wstrb_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [2:0]      offset_q, offset_d;
  logic [7:0]      mask_q, mask_d;
  logic            unsigned_q, unsigned_d;
  logic            misalign_err_q, misalign_err_d;
  logic            wb_load_valid_q, wb_load_valid_d;
  logic [XLEN-1:0] wb_load_data_q, wb_load_data_d;

  logic            presented;
  logic            align_ok;
  logic            accept;
  logic            reject;
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_ext;

  // Legal mask and natural alignment of the offset to the access size.
  always_comb begin
    align_ok = 1'b0;
    case (mem_write_width)
      8'h01:   align_ok = 1'b1;
      8'h03:   align_ok = (mem_addr[0] == 1'b0);
      8'h0F:   align_ok = (mem_addr[1:0] == 2'b00);
      8'hFF:   align_ok = (mem_addr[2:0] == 3'b000);
      default: align_ok = 1'b0;
    endcase
  end

  // The cycle showing misalign_err belongs to the trap flush, so the
  // instruction behind the rejected one is not started; this also keeps
  // stall and misalign_err from ever overlapping.
  always_comb begin
    presented = mem_valid & (mem_is_write_dmem | mem_is_read_dmem);
    accept    = (state_q == S_IDLE) && presented && align_ok && !misalign_err_q;
    reject    = (state_q == S_IDLE) && presented && !align_ok && !misalign_err_q;
  end

  always_comb begin
    rdata_shifted = dmem_rdata >> {offset_q, 3'b000};
    load_ext      = rdata_shifted;
    case (mask_q)
      8'h01: load_ext = unsigned_q ? {{(XLEN-8){1'b0}}, rdata_shifted[7:0]}
                                   : {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      8'h03: load_ext = unsigned_q ? {{(XLEN-16){1'b0}}, rdata_shifted[15:0]}
                                   : {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      8'h0F: load_ext = unsigned_q ? {{(XLEN-32){1'b0}}, rdata_shifted[31:0]}
                                   : {{(XLEN-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wstrb_d    = dmem_wstrb_q;
    dmem_wdata_d    = dmem_wdata_q;
    offset_d        = offset_q;
    mask_d          = mask_q;
    unsigned_d      = unsigned_q;
    misalign_err_d  = 1'b0;
    wb_load_valid_d = 1'b0;
    wb_load_data_d  = wb_load_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d      = S_REQ;
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_is_write_dmem;
          dmem_addr_d  = {mem_addr[XLEN-1:3], 3'b000};
          dmem_wstrb_d = mem_write_width << mem_addr[2:0];
          dmem_wdata_d = mem_dmem_write_data << {mem_addr[2:0], 3'b000};
          offset_d     = mem_addr[2:0];
          mask_d       = mem_write_width;
          unsigned_d   = mem_load_unsigned;
        end else if (reject) begin
          misalign_err_d = 1'b1;
        end
      end
      S_REQ: begin
        if (dmem_ack) begin
          state_d    = S_DONE;
          dmem_req_d = 1'b0;
          if (!dmem_we_q) begin
            wb_load_data_d  = load_ext;
            wb_load_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= S_IDLE;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wstrb_q    <= '0;
      dmem_wdata_q    <= '0;
      offset_q        <= '0;
      mask_q          <= '0;
      unsigned_q      <= 1'b0;
      misalign_err_q  <= 1'b0;
      wb_load_valid_q <= 1'b0;
      wb_load_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wstrb_q    <= dmem_wstrb_d;
      dmem_wdata_q    <= dmem_wdata_d;
      offset_q        <= offset_d;
      mask_q          <= mask_d;
      unsigned_q      <= unsigned_d;
      misalign_err_q  <= misalign_err_d;
      wb_load_valid_q <= wb_load_valid_d;
      wb_load_data_q  <= wb_load_data_d;
    end
  end

  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_wstrb    = dmem_wstrb_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign stall         = accept | (state_q == S_REQ);
  assign misalign_err  = misalign_err_q;
  assign wb_load_valid = wb_load_valid_q;
  assign wb_load_data  = wb_load_data_q;

endmodule

// File: tb/tb_mem_dmem_access.sv
// Scoreboard bench for mem_dmem_access: expected bus requests and load results
// are queued when an access is driven and compared when the DUT produces them.
module tb_mem_dmem_access;

  logic        sys_clk;
  logic        sys_rst;
  logic        mem_valid;
  logic        mem_is_write_dmem;
  logic        mem_is_read_dmem;
  logic [7:0]  mem_write_width;
  logic        mem_load_unsigned;
  logic [63:0] mem_addr;
  logic [63:0] mem_dmem_write_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_wstrb;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        stall;
  logic        misalign_err;
  logic        wb_load_valid;
  logic [63:0] wb_load_data;

  mem_dmem_access #(.XLEN(64)) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .mem_valid           (mem_valid),
    .mem_is_write_dmem   (mem_is_write_dmem),
    .mem_is_read_dmem    (mem_is_read_dmem),
    .mem_write_width     (mem_write_width),
    .mem_load_unsigned   (mem_load_unsigned),
    .mem_addr            (mem_addr),
    .mem_dmem_write_data (mem_dmem_write_data),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_wdata          (dmem_wdata),
    .dmem_ack            (dmem_ack),
    .dmem_rdata          (dmem_rdata),
    .stall               (stall),
    .misalign_err        (misalign_err),
    .wb_load_valid       (wb_load_valid),
    .wb_load_data        (wb_load_data)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [63:0] load_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  bit          gap_chk = 1'b0;
  logic        prev_req = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Byte-by-byte reference for an aligned, extended load.
  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [2:0] off,
                                             input logic [7:0] mask, input logic uns);
    int          n = $countones(mask);
    int          o = int'(off);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
    if (!uns && n < 8 && v[8*n-1]) begin
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  always @(negedge sys_clk) begin
    bus_t e;
    logic [63:0] exp_ld;
    cyc = cyc + 1;
    if (dmem_req && !prev_req) begin
      if (gap_chk) check("b2b_gap", 64'(cyc - fall_cyc), 64'd2);
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 64'd1, 64'd0);
      end else begin
        e = bus_q.pop_front();
        check("bus_addr", dmem_addr, e.addr);
        check("bus_we", 64'(dmem_we), 64'(e.we));
        if (e.we) begin
          check("bus_wstrb", 64'(dmem_wstrb), 64'(e.wstrb));
          check("bus_wdata", dmem_wdata & lane_mask(e.wstrb), e.wdata & lane_mask(e.wstrb));
        end
        $display("bus txn: addr=0x%016h we=%0d wstrb=0x%02h wdata=0x%016h",
                 dmem_addr, dmem_we, dmem_wstrb, dmem_wdata);
      end
    end
    if (!dmem_req && prev_req) fall_cyc = cyc;
    if (wb_load_valid) begin
      if (load_q.size() == 0) begin
        check("load_unexpected", 64'd1, 64'd0);
      end else begin
        exp_ld = load_q.pop_front();
        check("load_data", wb_load_data, exp_ld);
        $display("load txn: data=0x%016h", wb_load_data);
      end
    end
    if (stall || misalign_err || wb_load_valid)
      check("exclusive", 64'($countones({stall, misalign_err, wb_load_valid})), 64'd1);
    prev_req = dmem_req;
  end

  task automatic do_access(input logic we, input logic re, input logic [7:0] mask,
                           input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int delay, input logic [63:0] exp_load);
    bus_t e;
    int   stall_n = 0;
    @(posedge sys_clk); #1;
    mem_valid = 1'b1; mem_is_write_dmem = we; mem_is_read_dmem = re;
    mem_write_width = mask; mem_load_unsigned = uns; mem_addr = addr;
    mem_dmem_write_data = wdata; dmem_ack = 1'b0;
    e.addr  = {addr[63:3], 3'b000};
    e.we    = we;
    e.wstrb = mask << addr[2:0];
    e.wdata = wdata << (8 * addr[2:0]);
    bus_q.push_back(e);
    if (!we) load_q.push_back(exp_load);
    $display("drive txn: we=%0d mask=0x%02h uns=%0d addr=0x%016h delay=%0d", we, mask, uns, addr, delay);
    @(negedge sys_clk);
    if (stall) stall_n++;
    check("req_early", 64'(dmem_req), 64'd0);
    @(posedge sys_clk); #1;
    repeat (delay) begin
      @(negedge sys_clk);
      if (stall) stall_n++;
      @(posedge sys_clk); #1;
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(negedge sys_clk);
    if (stall) stall_n++;
    check("req_held", 64'(dmem_req), 64'd1);
    @(posedge sys_clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge sys_clk);
    check("done_stall", 64'(stall), 64'd0);
    check("done_req", 64'(dmem_req), 64'd0);
    check("done_wbv", 64'(wb_load_valid), 64'(!we));
    check("stall_cycles", 64'(stall_n), 64'(2 + delay));
  endtask

  task automatic do_misaligned(input logic [7:0] mask, input logic [63:0] addr);
    @(posedge sys_clk); #1;
    mem_valid = 1'b1; mem_is_write_dmem = 1'b0; mem_is_read_dmem = 1'b1;
    mem_write_width = mask; mem_load_unsigned = 1'b0; mem_addr = addr; dmem_ack = 1'b0;
    $display("drive txn: misaligned mask=0x%02h addr=0x%016h", mask, addr);
    @(negedge sys_clk);
    check("mis_stall", 64'(stall), 64'd0);
    @(posedge sys_clk); #1;
    mem_valid = 1'b0;
    @(negedge sys_clk);
    check("mis_err", 64'(misalign_err), 64'd1);
    check("mis_req", 64'(dmem_req), 64'd0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("mis_err_once", 64'(misalign_err), 64'd0);
    check("mis_req2", 64'(dmem_req), 64'd0);
  endtask

  task automatic go_idle(input int n);
    @(posedge sys_clk); #1;
    mem_valid = 1'b0; mem_is_write_dmem = 1'b0; mem_is_read_dmem = 1'b0;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  masks [4];
    logic [7:0]  m;
    logic [2:0]  off;
    logic [63:0] a, wd, rd;
    logic        w, u;
    bus_t        e;
    masks[0] = 8'h01; masks[1] = 8'h03; masks[2] = 8'h0F; masks[3] = 8'hFF;

    sys_rst = 1'b1; mem_valid = 1'b0; mem_is_write_dmem = 1'b0; mem_is_read_dmem = 1'b0;
    mem_write_width = 8'h00; mem_load_unsigned = 1'b0; mem_addr = '0;
    mem_dmem_write_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_we", 64'(dmem_we), 64'd0);
    check("rst_addr", dmem_addr, 64'd0);
    check("rst_wstrb", 64'(dmem_wstrb), 64'd0);
    check("rst_wdata", dmem_wdata, 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mis", 64'(misalign_err), 64'd0);
    check("rst_wbv", 64'(wb_load_valid), 64'd0);
    check("rst_wbdata", wb_load_data, 64'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // Store byte, ack on first REQ cycle.
    do_access(1'b1, 1'b0, 8'h01, 1'b0, 64'h1003, 64'hAB, 64'h0, 0, 64'h0);
    go_idle(1);
    // Signed half load after 3 wait cycles.
    do_access(1'b0, 1'b1, 8'h03, 1'b0, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 3,
              64'hFFFF_FFFF_FFFF_8001);
    go_idle(1);
    // Unsigned word load.
    do_access(1'b0, 1'b1, 8'h0F, 1'b1, 64'h2004, 64'h0, 64'hF000_0000_1234_5678, 1,
              64'h0000_0000_F000_0000);
    go_idle(1);

    do_misaligned(8'h0F, 64'h3002);
    do_misaligned(8'h07, 64'h3000);
    go_idle(1);

    // Valid but no access requested: nothing happens.
    @(posedge sys_clk); #1;
    mem_valid = 1'b1; mem_is_write_dmem = 1'b0; mem_is_read_dmem = 1'b0; mem_write_width = 8'hFF;
    @(negedge sys_clk);
    check("noacc_stall", 64'(stall), 64'd0);
    @(posedge sys_clk); #1;
    mem_is_write_dmem = 1'b1; mem_valid = 1'b0;
    @(negedge sys_clk);
    check("novalid_stall", 64'(stall), 64'd0);
    check("noacc_req", 64'(dmem_req), 64'd0);

    // Read and write both set: the store wins.
    do_access(1'b1, 1'b1, 8'hFF, 1'b0, 64'h5008, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 64'h0);
    go_idle(1);

    // Reset while the request is outstanding, then a late ack.
    @(posedge sys_clk); #1;
    mem_valid = 1'b1; mem_is_write_dmem = 1'b0; mem_is_read_dmem = 1'b1;
    mem_write_width = 8'hFF; mem_load_unsigned = 1'b0; mem_addr = 64'h4000;
    e.addr = 64'h4000; e.we = 1'b0; e.wstrb = 8'hFF; e.wdata = '0;
    bus_q.push_back(e);
    $display("drive txn: load addr=0x%016h aborted by reset", mem_addr);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("rstreq_req", 64'(dmem_req), 64'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1; mem_valid = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 64'h1111_2222_3333_4444;
    @(negedge sys_clk);
    check("rstreq_req_low", 64'(dmem_req), 64'd0);
    check("rstreq_stall", 64'(stall), 64'd0);
    @(posedge sys_clk); #1;
    dmem_ack = 1'b0;
    @(negedge sys_clk);
    check("rstreq_wbv", 64'(wb_load_valid), 64'd0);
    check("rstreq_wbdata", wb_load_data, 64'd0);
    go_idle(1);

    // Back-to-back store then load, each acked on the first REQ cycle.
    do_access(1'b1, 1'b0, 8'h0F, 1'b0, 64'h6004, 64'hCAFE_F00D, 64'h0, 0, 64'h0);
    gap_chk = 1'b1;
    do_access(1'b0, 1'b1, 8'h01, 1'b0, 64'h6007, 64'h0, 64'h8000_0000_0000_0000, 0,
              64'hFFFF_FFFF_FFFF_FF80);
    gap_chk = 1'b0;
    go_idle(1);

    // Random legal accesses checked against the byte-lane model.
    for (int t = 0; t < 10; t++) begin
      m   = masks[$urandom_range(0, 3)];
      off = 3'($urandom_range(0, 7)) & ~3'($countones(m) - 1);
      a   = {32'h0, $urandom} & ~64'h7 | 64'(off);
      wd  = {$urandom, $urandom};
      rd  = {$urandom, $urandom};
      w   = 1'($urandom_range(0, 1));
      u   = 1'($urandom_range(0, 1));
      do_access(w, !w, m, u, a, wd, rd, $urandom_range(0, 3), model_load(rd, off, m, u));
    end
    go_idle(2);

    check("sb_bus_empty", 64'(bus_q.size()), 64'd0);
    check("sb_load_empty", 64'(load_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_dmem_access.md
Name: mem_dmem_access

Overview:
- MEM-stage data-memory access unit.
- Consumes the store/load controls registered into the MEM stage (write enable, byte-width mask, store data, address).
- Drives a req/ack handshake to data memory and stalls the pipeline while the access is outstanding.
- Returns aligned, sign- or zero-extended load data to the writeback path.

Parameters:
XLEN, 64, data and address width; must be 64 (8 byte lanes).

Ports:
sys_clk  input  1  clock, all state updates on rising edge
sys_rst  input  1  reset, synchronous, active-high
mem_valid  input  1  MEM-stage instruction valid
mem_is_write_dmem  input  1  store request
mem_is_read_dmem  input  1  load request; if both this and mem_is_write_dmem are high, the store wins
mem_write_width  input  8  unshifted byte mask; legal values 0x01, 0x03, 0x0F, 0xFF (used for loads and stores)
mem_load_unsigned  input  1  1 = zero-extend load, 0 = sign-extend
mem_addr  input  XLEN  byte address
mem_dmem_write_data  input  XLEN  store data, right-justified
dmem_req  output  1  bus request
dmem_we  output  1  bus write enable
dmem_addr  output  XLEN  doubleword-aligned address ({mem_addr[63:3],3'b0})
dmem_wstrb  output  8  byte strobes (mask << addr[2:0])
dmem_wdata  output  XLEN  store data << (8*addr[2:0])
dmem_ack  input  1  bus completion; rdata valid in the same cycle
dmem_rdata  input  XLEN  read data
stall  output  1  freeze IF..MEM pipeline registers
misalign_err  output  1  one-cycle pulse, access rejected
wb_load_valid  output  1  one-cycle pulse, wb_load_data valid
wb_load_data  output  XLEN  extended load result

Behaviour:
- States: IDLE, REQ, DONE. Reset (sync, high): state=IDLE; dmem_req, dmem_we, dmem_wstrb, dmem_wdata, dmem_addr, misalign_err, wb_load_valid, wb_load_data all 0. Reset in any state aborts the transaction. A dmem_ack arriving after reset is ignored.
- Access is "presented" when mem_valid & (mem_is_write_dmem | mem_is_read_dmem).
- Misaligned: mask not in {0x01, 0x03, 0x0F, 0xFF}, or addr[2:0] not a multiple of the access size.
- IDLE, misaligned access presented:
  - misalign_err=1 next cycle for exactly one cycle.
  - No bus request; stall stays 0; state stays IDLE.
- IDLE, legal access presented:
  - stall=1 combinationally in this cycle.
  - At the edge, register dmem_addr, dmem_we, shifted dmem_wstrb, shifted dmem_wdata, offset, mask and unsigned flag.
  - Next state REQ.
- REQ:
  - dmem_req=1 and stall=1; request fields held stable until ack.
  - dmem_ack sampled high -> next state DONE.
  - For a load, at that edge wb_load_data = extend((dmem_rdata >> 8*offset) & byte-mask). Sign bit is bit 7/15/31 for mask 0x01/0x03/0x0F; 0xFF is not extended.
  - Ack in the first REQ cycle is legal (minimum latency).
  - No timeout; REQ holds indefinitely.
- DONE:
  - dmem_req=0, stall=0; wb_load_valid=1 for loads, 0 for stores.
  - MEM inputs are ignored this cycle; they still show the same instruction, which leaves at this edge.
  - Next state IDLE.
  - Back-to-back accesses therefore cost at least 3 cycles each.
- dmem_ack outside REQ is ignored.
- stall, misalign_err and wb_load_valid are never high simultaneously.
- mem_valid=0 in IDLE: no action, all pulses 0.
- Store data/strobes: only lanes in dmem_wstrb are meaningful; unmasked lanes of dmem_wdata carry the shifted value without further masking.

Test Plan:
- Store byte: addr=0x1003, mask=0x01, data=0xAB, ack on first REQ cycle -> dmem_addr=0x1000, wstrb=0x08, wdata[31:24]=0xAB. stall high for 2 cycles then low in DONE. wb_load_valid stays 0.
- Signed half load: addr=0x2006, mask=0x03, unsigned=0, rdata=0x8001_0000_0000_0000, ack after 3 wait cycles -> wb_load_data=0xFFFF_FFFF_FFFF_8001, wb_load_valid one cycle. stall high for 5 cycles.
- Unsigned word load: addr=0x2004, mask=0x0F, unsigned=1, rdata=0xF000_0000_xxxx_xxxx -> wb_load_data=0x0000_0000_F000_0000.
- Misaligned: mask=0x0F, addr=0x3002 -> misalign_err pulses once, dmem_req never asserts, stall stays 0.
- Reset mid-REQ: sys_rst high for one cycle while dmem_req=1, then dmem_ack high the following cycle -> state IDLE, dmem_req=0 after the reset edge, late ack ignored (no wb_load_valid).
- Back-to-back: store then load presented on consecutive instructions, each ack on first REQ cycle -> second dmem_req rises exactly 2 cycles after the first falls. No input sampled during DONE.
